// File: rtl/req_chan_subn.sv
// Request-channel FIFO that routes each head entry to one of NSUB subordinate ports or to a decode-error port.
// Latency: a push into an empty queue is presented as the head one cycle later; there is no same-cycle flow-through.
// Backpressure: a_ready drops while the queue holds DEPTH entries, and a head whose target is not ready stalls every later entry.
module req_chan_subn #(
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 4,
   parameter int NSUB    = 2,
   parameter int SEL_LSB = 28
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [ID_W-1:0]            a_id,
   input  logic [ADDR_W-1:0]          a_addr,
   input  logic [5:0]                 a_atop,
   output logic [NSUB-1:0]            reqc_s_valid,
   input  logic [NSUB-1:0]            reqc_s_ready,
   output logic [ID_W-1:0]            reqc_s_id,
   output logic [ADDR_W-1:0]          reqc_s_addr,
   output logic                       reqc_err_valid,
   input  logic                       reqc_err_ready,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int SEL_W = (NSUB > 1) ? $clog2(NSUB) : 1;
   localparam int SW1   = SEL_W + 1;
   localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
   localparam logic [SW1-1:0] NSUB_V = SW1'(NSUB);

   logic [ID_W-1:0]   id_mem   [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [AW-1:0]     wadr;
   logic [AW-1:0]     radr;
   logic [CW-1:0]     cnt;
   logic [SEL_W-1:0]  sel;
   logic              nonempty;
   logic              mapped;
   logic              push;
   logic              pop;
   logic              unused_atop;

   // Atomic ops carry no meaning for this channel.
   assign unused_atop = ^a_atop;

   assign a_ready     = (cnt != FULL);
   assign push        = a_valid & a_ready;
   assign nonempty    = (cnt != '0);
   assign reqc_s_id   = id_mem[radr];
   assign reqc_s_addr = addr_mem[radr];
   assign sel         = reqc_s_addr[SEL_LSB +: SEL_W];
   assign mapped      = ({1'b0, sel} < NSUB_V);
   assign q_count     = cnt;

   always_comb begin
      reqc_s_valid = '0;
      for (int i = 0; i < NSUB; i++) begin
         reqc_s_valid[i] = nonempty & mapped & (sel == SEL_W'(i));
      end
   end

   assign reqc_err_valid = nonempty & ~mapped;
   assign pop = (|(reqc_s_valid & reqc_s_ready)) | (reqc_err_valid & reqc_err_ready);

   // Payload array is deliberately left out of reset; cnt alone qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wadr]   <= a_id;
         addr_mem[wadr] <= a_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wadr <= '0;
         radr <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            wadr <= wadr + 1'b1;
         end
         if (pop) begin
            radr <= radr + 1'b1;
         end
         if (push && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_req_chan_subn.sv
// Bench for req_chan_subn: a NSUB=2 instance checked every cycle against a queue model, plus a NSUB=3 instance for decode errors.
module tb_req_chan_subn;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
   } ent_t;

   logic        clk;
   logic        rst_n;

   logic        a_valid, a_ready, err_valid, err_ready;
   logic [3:0]  a_id, s_id;
   logic [31:0] a_addr, s_addr;
   logic [5:0]  a_atop;
   logic [1:0]  s_valid, s_ready;
   logic [2:0]  q_count;

   logic        a_valid3, a_ready3, err_valid3, err_ready3;
   logic [3:0]  a_id3, s_id3;
   logic [31:0] a_addr3, s_addr3;
   logic [2:0]  s_valid3, s_ready3;
   logic [2:0]  q_count3;

   int   checks = 0;
   int   errors = 0;
   ent_t sb[$];

   req_chan_subn #(.ID_W(4), .ADDR_W(32), .DEPTH(4), .NSUB(2), .SEL_LSB(28)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_id(a_id), .a_addr(a_addr), .a_atop(a_atop),
      .reqc_s_valid(s_valid), .reqc_s_ready(s_ready), .reqc_s_id(s_id), .reqc_s_addr(s_addr),
      .reqc_err_valid(err_valid), .reqc_err_ready(err_ready), .q_count(q_count)
   );

   req_chan_subn #(.ID_W(4), .ADDR_W(32), .DEPTH(4), .NSUB(3), .SEL_LSB(28)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid3), .a_ready(a_ready3), .a_id(a_id3), .a_addr(a_addr3), .a_atop(a_atop),
      .reqc_s_valid(s_valid3), .reqc_s_ready(s_ready3), .reqc_s_id(s_id3), .reqc_s_addr(s_addr3),
      .reqc_err_valid(err_valid3), .reqc_err_ready(err_ready3), .q_count(q_count3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int port_of(input logic [31:0] addr);
      return int'(addr[28]);
   endfunction

   // One clock of the NSUB=2 instance: check outputs mid-cycle against the model, then advance the model.
   task automatic cycle();
      logic [1:0] exp_v;
      logic       exp_rdy;
      logic       do_push;
      logic       do_pop;
      ent_t       e;
      @(negedge clk);
      exp_rdy = (sb.size() != 4);
      exp_v   = 2'b00;
      if (sb.size() != 0) exp_v = 2'b01 << port_of(sb[0].addr);
      chk("a_ready", a_ready, exp_rdy);
      chk("q_count", q_count, sb.size());
      chk("s_valid", s_valid, exp_v);
      chk("err_valid", err_valid, 1'b0);
      if (sb.size() != 0) begin
         chk("head_id", s_id, sb[0].id);
         chk("head_addr", s_addr, sb[0].addr);
      end
      do_push = a_valid && exp_rdy;
      do_pop  = (sb.size() != 0) && s_ready[port_of(sb[0].addr)];
      e.id    = a_id;
      e.addr  = a_addr;
      @(posedge clk);
      #1;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(e);
   endtask

   task automatic push_one(input logic [3:0] id, input logic [31:0] addr);
      a_valid = 1'b1;
      a_id    = id;
      a_addr  = addr;
      cycle();
      a_valid = 1'b0;
   endtask

   task automatic drain();
      s_ready = 2'b11;
      for (int k = 0; k < 50 && sb.size() != 0; k++) cycle();
      chk("drain_left", sb.size(), 0);
      s_ready = 2'b00;
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_id = '0; a_addr = '0; a_atop = 6'h2a;
      s_ready = 2'b00; err_ready = 1'b0;
      a_valid3 = 1'b0; a_id3 = '0; a_addr3 = '0; s_ready3 = 3'b000; err_ready3 = 1'b0;
      #12;
      chk("rst_a_ready", a_ready, 1'b1);
      chk("rst_s_valid", s_valid, 2'b00);
      chk("rst_err_valid", err_valid, 1'b0);
      chk("rst_q_count", q_count, 3'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single request to port 0, then pop.
      push_one(4'd3, 32'h0000_1000);
      cycle();
      s_ready = 2'b01;
      cycle();
      s_ready = 2'b00;
      cycle();

      // Fill to DEPTH, fifth request held until a pop frees a slot.
      for (int k = 0; k < 4; k++) push_one(4'(k + 4), 32'h0000_0100 + 32'(k));
      a_valid = 1'b1; a_id = 4'd9; a_addr = 32'h1000_0200;
      cycle();
      cycle();
      s_ready = 2'b01;
      cycle();
      s_ready = 2'b00;
      cycle();
      a_valid = 1'b0;
      cycle();
      drain();

      // Head bound for a stalled port blocks a later entry for a ready port.
      s_ready = 2'b01;
      push_one(4'd1, 32'h1000_0000);
      push_one(4'd2, 32'h0000_0040);
      cycle();
      cycle();
      s_ready = 2'b11;
      cycle();
      cycle();
      cycle();
      s_ready = 2'b00;

      // Continuous streaming with wrapping ids and alternating ports.
      s_ready = 2'b11;
      for (int i = 0; i < 20; i++) begin
         a_valid = 1'b1;
         a_id    = 4'(i % 16);
         a_addr  = (32'(i % 2) << 28) | (32'(i) << 4);
         cycle();
      end
      a_valid = 1'b0;
      drain();

      // Reset mid-stream discards queued entries.
      for (int k = 0; k < 3; k++) push_one(4'(k + 12), 32'h0000_0500 + 32'(k));
      rst_n = 1'b0;
      #1;
      chk("midrst_s_valid", s_valid, 2'b00);
      chk("midrst_q_count", q_count, 3'd0);
      chk("midrst_a_ready", a_ready, 1'b1);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_one(4'd10, 32'h1000_0300);
      cycle();
      drain();

      // NSUB=3: select value 3 is unmapped and goes to the error port.
      a_valid3 = 1'b1; a_id3 = 4'd7; a_addr3 = 32'h3000_0000;
      @(negedge clk);
      chk("e_a_ready", a_ready3, 1'b1);
      @(posedge clk);
      #1;
      a_id3 = 4'd8; a_addr3 = 32'h0000_0040;
      @(negedge clk);
      chk("e_err_valid", err_valid3, 1'b1);
      chk("e_s_valid", s_valid3, 3'b000);
      chk("e_q_count", q_count3, 3'd1);
      chk("e_head_id", s_id3, 4'd7);
      @(posedge clk);
      #1;
      a_valid3 = 1'b0;
      err_ready3 = 1'b1;
      @(negedge clk);
      chk("e_err_held", err_valid3, 1'b1);
      chk("e_q_count2", q_count3, 3'd2);
      @(posedge clk);
      #1;
      err_ready3 = 1'b0;
      @(negedge clk);
      chk("e_err_clear", err_valid3, 1'b0);
      chk("e_next_valid", s_valid3, 3'b001);
      chk("e_next_id", s_id3, 4'd8);
      chk("e_next_addr", s_addr3, 32'h0000_0040);
      @(posedge clk);
      #1;
      s_ready3 = 3'b001;
      @(negedge clk);
      @(posedge clk);
      #1;
      s_ready3 = 3'b000;
      @(negedge clk);
      chk("e_empty_valid", s_valid3, 3'b000);
      chk("e_empty_q", q_count3, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/req_chan_subn.md
# req_chan_subn

Parametrised request-channel manager on the subordinate side of the tiny AXI-style bus. It accepts address requests (id, addr) from the bus, buffers them in a FIFO of configurable depth, and decodes each head entry's address to one of NSUB subordinate output ports. Each output port has a valid/ready handshake. Out-of-range addresses go to a dedicated decode-error port. It replaces the single-subordinate, fixed-depth, no-backpressure request manager.

## Interface
Parameters:
- ID_W, 4, request id width
- ADDR_W, 32, request address width
- DEPTH, 4, FIFO entries; power of two, 2..64
- NSUB, 2, number of subordinate ports, 1..8
- SEL_LSB, 28, LSB of the subordinate-select field in the address; SEL_W = max(1, clog2(NSUB)) bits; SEL_LSB+SEL_W <= ADDR_W

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  bus request valid
- a_ready  out  1  bus request ready
- a_id  in  ID_W  request id
- a_addr  in  ADDR_W  request address
- a_atop  in  6  atomic op; accepted and ignored
- reqc_s_valid  out  NSUB  per-subordinate valid, at most one bit set
- reqc_s_ready  in  NSUB  per-subordinate ready
- reqc_s_id  out  ID_W  head id, shared by all ports
- reqc_s_addr  out  ADDR_W  head address, shared by all ports
- reqc_err_valid  out  1  head entry has an unmapped address
- reqc_err_ready  in  1  error sink ready
- q_count  out  clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH x (ID_W+ADDR_W) flop array, write pointer wadr, read pointer radr, each clog2(DEPTH) bits, plus an occupancy counter cnt.
- a_ready = (cnt != DEPTH). There is no full-bypass: when full, a_ready=0 even if a pop occurs in the same cycle.
- push = a_valid & a_ready. On push, write {a_id, a_addr} at wadr; wadr wraps naturally modulo DEPTH.
- head = entry[radr]. reqc_s_id and reqc_s_addr are driven combinationally from the head. Their value is don't-care when empty.
- sel = head addr[SEL_LSB +: SEL_W]. The head is mapped if sel < NSUB.
- When cnt != 0 and the head is mapped: reqc_s_valid[sel] = 1, all other bits 0, reqc_err_valid = 0.
- When cnt != 0 and the head is unmapped: reqc_s_valid = 0, reqc_err_valid = 1.
- pop = (reqc_s_valid & reqc_s_ready) != 0, or (reqc_err_valid & reqc_err_ready). On pop, radr increments, wrapping.
- Counter: push & pop leaves cnt unchanged; push alone increments cnt; pop alone decrements it. cnt never exceeds DEPTH and never underflows.
- In-order: a blocked head (target ready low) stalls all later entries, even those bound for other ports.
- Ready bits for non-selected ports are ignored.
- Once valid is asserted for a head, valid and data stay stable until pop, per AXI rules.
- q_count = cnt.

## Timing
- Reset values (async, immediate): wadr=0, radr=0, cnt=0, so a_ready=1, reqc_s_valid=0, reqc_err_valid=0, q_count=0. Array contents are not reset.
- Reset mid-operation discards all queued entries. The first push after reset release lands in entry 0.
- Latency: a push in cycle N gives head valid in cycle N+1 when the FIFO was empty. There is no same-cycle flow-through.
- Throughput: one push and one pop per cycle sustained. A full FIFO recovers a_ready in the cycle after a pop.
- Simultaneous push and pop on a 1-entry FIFO: the new entry becomes head in the next cycle, and valid stays high without a gap.
- Wrap-around: after DEPTH pushes, wadr returns to 0. Pointer equality alone is never used for full/empty; cnt decides.

## Test plan
- Reset, then push id=3 addr=0x0000_1000 with all readys low. Expect a_ready=1 at reset. Expect reqc_s_valid=2'b01 the next cycle and q_count=1. Raise reqc_s_ready[0]: expect pop, then valid=0 and q_count=0.
- DEPTH=4, readys low, push 5 back-to-back. Expect a_ready to drop after the 4th accept, q_count=4, and the 5th request held. One pop, then a_ready=1 in the following cycle and the 5th accepted.
- NSUB=2, SEL_LSB=28. Push addr 0x1000_0000 (port 1), then 0x0000_0040 (port 0), with ready[0]=1 and ready[1]=0. Expect valid=2'b10 stalled and the port-0 request not issued. Raise ready[1]: expect two pops in order.
- NSUB=3, SEL_W=2. Push addr 0x3000_0000 (sel=3). Expect reqc_err_valid=1 and reqc_s_valid=0. Pop via reqc_err_ready, and expect the following entry to present normally.
- Continuous push and pop, all readys=1, 20 requests with ids 0..15 wrapping. Expect the output order to equal the input order, q_count constant at 1 after the first cycle, and pointers to wrap without loss.
- Fill 3 entries, assert rst_n=0 for one cycle mid-stream. Expect all valids=0 and q_count=0 immediately. After release, a new push appears with its own id/addr only.
